// File: rtl/mem_pkg.sv
// Constants shared by the DRAM request queue and the bank controller:
// op codes, request field layout and the legal address window.
package mem_pkg;

  localparam int REQ_ADDR_LSB = 0;
  localparam int REQ_ADDR_MSB = 31;
  localparam int REQ_OP_LSB   = 32;
  localparam int REQ_OP_MSB   = 33;
  localparam int REQ_ID_LSB   = 34;
  localparam int REQ_ID_MSB   = 37;
  localparam int ID_W         = REQ_ID_MSB - REQ_ID_LSB + 1;

  localparam logic [31:0] BOUNDARY_LOW = 32'h0000_0000;
  localparam logic [31:0] BOUNDARY_UP  = 32'h0000_1FFF;

  typedef enum logic [1:0] {
    OP_RD  = 2'b00,
    OP_WR  = 2'b01,
    OP_PWB = 2'b10,
    OP_BAD = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_POP_WAIT,
    ST_ACCESS,
    ST_READ,
    ST_RESP
  } state_e;

  // The window starts at address 0, so only the upper bound can be violated.
  function automatic logic req_is_bad(input op_e op, input logic [31:0] addr);
    return (op == OP_BAD) || (addr > BOUNDARY_UP);
  endfunction

endpackage

// File: rtl/dram_array.sv
// Single-port synchronous line store; read data appears the cycle after i_re.
module dram_array #(
  parameter int DEPTH      = 512,
  parameter int IDX_W      = 9,
  parameter int DATA_WIDTH = 128
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic                  i_re,
  input  logic [IDX_W-1:0]      i_idx,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_idx] <= i_wdata;
    if (i_re) r_rdata <= r_mem[i_idx];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/dram_bank_ctrl.sv
// DRAM bank controller: services one queued request at a time, commits line
// writes after a fixed latency and streams read lines back as beats, MSW first.
module dram_bank_ctrl
  import mem_pkg::*;
#(
  parameter int REQUEST_SIZE   = 38,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 128,
  parameter int MEM_DEPTH      = 512,
  parameter int MEM_INDEX_BIT  = 9,
  parameter int ACCESS_LATENCY = 8,
  parameter int CYCLE_NUM_DATA = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    q_empty,
  output logic                    q_pop_en,
  input  logic                    q_valid,
  input  logic [REQUEST_SIZE-1:0] q_req,
  input  logic [DATA_WIDTH-1:0]   q_data,
  input  logic                    resp_ready,
  output logic                    resp_valid,
  output logic [31:0]             resp_data,
  output logic                    resp_last,
  output logic [ID_W-1:0]         resp_id,
  output logic                    busy,
  output logic                    err_pulse
);

  localparam int BEAT_W = DATA_WIDTH / CYCLE_NUM_DATA;
  localparam int BCNT_W = $clog2(CYCLE_NUM_DATA);
  localparam int LAT_W  = $clog2(ACCESS_LATENCY) + 1;
  localparam logic [BCNT_W-1:0] LAST_BEAT = BCNT_W'(CYCLE_NUM_DATA - 1);

  state_e                   r_state;
  logic [LAT_W-1:0]         r_lat;
  logic [BCNT_W-1:0]        r_beat;
  logic [ADDR_WIDTH-1:0]    r_addr;
  op_e                      r_op;
  logic [ID_W-1:0]          r_id;
  logic [DATA_WIDTH-1:0]    r_line;
  logic                     r_err;

  logic                     w_bad;
  logic                     w_access_done;
  logic                     w_we;
  logic                     w_re;
  logic [MEM_INDEX_BIT-1:0] w_idx;
  logic [DATA_WIDTH-1:0]    w_rdata;

  assign w_idx         = r_addr[MEM_INDEX_BIT+3:4];
  assign w_bad         = req_is_bad(r_op, r_addr);
  // Gating with rst guarantees a reset in the final access cycle aborts the write.
  assign w_access_done = (r_state == ST_ACCESS) && (r_lat == '0) && !rst;
  assign w_we          = w_access_done && !w_bad && ((r_op == OP_WR) || (r_op == OP_PWB));
  assign w_re          = w_access_done && !w_bad && (r_op == OP_RD);

  dram_array #(
    .DEPTH      (MEM_DEPTH),
    .IDX_W      (MEM_INDEX_BIT),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_array (
    .clk     (clk),
    .i_we    (w_we),
    .i_re    (w_re),
    .i_idx   (w_idx),
    .i_wdata (r_line),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clk) begin
    r_err <= 1'b0;
    if (rst) begin
      r_state <= ST_IDLE;
      r_lat   <= '0;
      r_beat  <= '0;
      r_id    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (!q_empty) r_state <= ST_POP_WAIT;
        end
        ST_POP_WAIT: begin
          // The head may still be collecting write data; drop back and pop again.
          if (q_valid) begin
            r_addr  <= q_req[REQ_ADDR_MSB:REQ_ADDR_LSB];
            r_op    <= op_e'(q_req[REQ_OP_MSB:REQ_OP_LSB]);
            r_id    <= q_req[REQ_ID_MSB:REQ_ID_LSB];
            r_line  <= q_data;
            r_lat   <= LAT_W'(ACCESS_LATENCY - 1);
            r_state <= ST_ACCESS;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_ACCESS: begin
          if (r_lat != '0) begin
            r_lat <= r_lat - 1'b1;
          end else if (w_bad) begin
            r_err   <= 1'b1;
            r_state <= ST_IDLE;
          end else if (r_op == OP_RD) begin
            r_state <= ST_READ;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_READ: begin
          r_line  <= w_rdata;
          r_beat  <= '0;
          r_state <= ST_RESP;
        end
        ST_RESP: begin
          if (resp_ready) begin
            if (r_beat == LAST_BEAT) begin
              r_beat  <= '0;
              r_state <= ST_IDLE;
            end else begin
              r_beat <= r_beat + 1'b1;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign q_pop_en   = !rst && (r_state == ST_IDLE) && !q_empty;
  assign busy       = (r_state != ST_IDLE);
  assign err_pulse  = r_err;
  assign resp_valid = (r_state == ST_RESP);
  assign resp_last  = resp_valid && (r_beat == LAST_BEAT);
  assign resp_id    = resp_valid ? r_id : '0;
  assign resp_data  = resp_valid ? r_line[DATA_WIDTH-1-BEAT_W*int'(r_beat) -: BEAT_W] : '0;

endmodule

// File: tb/tb_dram_bank_ctrl.sv
// Bench for dram_bank_ctrl: a behavioural request queue feeds the controller,
// read beats are checked against a scoreboard filled from a line-level memory model.
module tb_dram_bank_ctrl;
  import mem_pkg::*;

  localparam int LAT = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         q_empty;
  logic         q_pop_en;
  logic         q_valid;
  logic [37:0]  q_req;
  logic [127:0] q_data;
  logic         resp_ready;
  logic         resp_valid;
  logic [31:0]  resp_data;
  logic         resp_last;
  logic [3:0]   resp_id;
  logic         busy;
  logic         err_pulse;

  always #5 clk = ~clk;

  dram_bank_ctrl #(.ACCESS_LATENCY(LAT)) dut (
    .clk        (clk),
    .rst        (rst),
    .q_empty    (q_empty),
    .q_pop_en   (q_pop_en),
    .q_valid    (q_valid),
    .q_req      (q_req),
    .q_data     (q_data),
    .resp_ready (resp_ready),
    .resp_valid (resp_valid),
    .resp_data  (resp_data),
    .resp_last  (resp_last),
    .resp_id    (resp_id),
    .busy       (busy),
    .err_pulse  (err_pulse)
  );

  typedef struct packed {
    logic [37:0]  req;
    logic [127:0] data;
  } qent_t;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
    logic [3:0]  id;
  } beat_t;

  qent_t        fifo[$];
  beat_t        sb[$];
  logic [127:0] mdl [int];

  int checks = 0, failures = 0;
  int cyc = 0, pops = 0, pop_cyc = 0, pop_viol = 0;
  int first_lat = -1, err_cnt = 0, err_run = 0, err_long = 0;
  int ready_mode = 0, rk = 0;
  bit withhold = 1'b0;
  bit pop_seen, prev_valid = 1'b0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // Queue a request; commit=1 means the model expects it to take effect.
  task automatic enq(input logic [1:0] op, input logic [31:0] addr, input logic [3:0] id,
                     input logic [127:0] data, input bit commit);
    qent_t e;
    beat_t b;
    logic [127:0] line;
    int idx;
    e.req  = {id, op, addr};
    e.data = data;
    fifo.push_back(e);
    idx = int'(addr[12:4]);
    if (commit && (op == OP_WR || op == OP_PWB)) mdl[idx] = data;
    if (commit && op == OP_RD) begin
      line = mdl[idx];
      for (int k = 0; k < 4; k++) begin
        b.data = line[127:96];
        b.last = (k == 3);
        b.id   = id;
        sb.push_back(b);
        line = line << 32;
      end
    end
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (!(fifo.size() == 0 && !busy && sb.size() == 0) && n < 300) begin
      step();
      n++;
    end
    chk({"idle_timeout_", tag}, 128'(n < 300), 128'(1));
    step(2);
  endtask

  // Request queue model: answers a pop one cycle later, optionally withholding valid once.
  initial begin
    q_valid = 1'b0;
    q_req = '0;
    q_data = '0;
    q_empty = 1'b1;
    resp_ready = 1'b1;
    forever begin
      @(negedge clk);
      pop_seen = q_pop_en;
      if (q_pop_en) begin
        pops++;
        pop_cyc = cyc;
        if (busy || q_empty) pop_viol++;
      end
      @(posedge clk);
      #1;
      cyc++;
      q_valid = 1'b0;
      if (pop_seen && fifo.size() > 0) begin
        if (withhold) begin
          withhold = 1'b0;
        end else begin
          q_valid = 1'b1;
          q_req   = fifo[0].req;
          q_data  = fifo[0].data;
          void'(fifo.pop_front());
        end
      end
      q_empty = (fifo.size() == 0);
      rk++;
      resp_ready = (ready_mode == 0) ? 1'b1 : ((rk % 3) == 0);
    end
  end

  // Response monitor: every valid beat must equal the scoreboard head until it is accepted.
  initial begin
    forever begin
      @(negedge clk);
      if (err_pulse) begin
        err_cnt++;
        err_run++;
      end else begin
        err_run = 0;
      end
      if (err_run > 1) err_long++;
      if (resp_valid) begin
        if (!prev_valid) first_lat = cyc - pop_cyc;
        if (sb.size() > 0) begin
          chk("beat_data", 128'(resp_data), 128'(sb[0].data));
          chk("beat_last", 128'(resp_last), 128'(sb[0].last));
          chk("beat_id", 128'(resp_id), 128'(sb[0].id));
          if (resp_ready) void'(sb.pop_front());
        end else begin
          chk("unexpected_beat", 128'(resp_valid), 128'(0));
        end
      end
      prev_valid = resp_valid;
    end
  end

  initial begin
    int p0, e0, n;
    rst = 1'b1;
    step(3);
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_resp_valid", 128'(resp_valid), 128'(0));
    chk("rst_resp_data", 128'(resp_data), 128'(0));
    chk("rst_resp_last", 128'(resp_last), 128'(0));
    chk("rst_resp_id", 128'(resp_id), 128'(0));
    chk("rst_err", 128'(err_pulse), 128'(0));
    chk("rst_pop", 128'(q_pop_en), 128'(0));
    rst = 1'b0;
    step(2);

    // Write then read back the same line.
    enq(OP_WR, 32'h40, 4'd1, 128'h11112222_33334444_55556666_77778888, 1'b1);
    enq(OP_RD, 32'h40, 4'd3, '0, 1'b1);
    wait_idle("wr_rd");

    // Read with a stalling consumer; first-beat latency measured from the pop.
    ready_mode = 1;
    enq(OP_RD, 32'h4C, 4'd5, '0, 1'b1);
    wait_idle("stall_rd");
    chk("first_beat_latency", 128'(first_lat), 128'(3 + LAT));
    ready_mode = 0;

    // Valid withheld on the first pop: controller must re-pop the same entry.
    p0 = pops;
    e0 = err_cnt;
    withhold = 1'b1;
    enq(OP_WR, 32'h50, 4'd2, 128'hA5A5A5A5_0F0F0F0F_DEADBEEF_01234567, 1'b1);
    wait_idle("withhold");
    chk("withhold_pops", 128'(pops - p0), 128'(2));
    chk("withhold_no_err", 128'(err_cnt - e0), 128'(0));
    enq(OP_RD, 32'h50, 4'd4, '0, 1'b1);
    wait_idle("withhold_rd");

    // Bad op and out-of-range address are dropped with a single-cycle error.
    enq(OP_WR, 32'h0, 4'd0, 128'hCAFEF00D_00000001_00000002_00000003, 1'b1);
    wait_idle("mem0_init");
    e0 = err_cnt;
    enq(OP_BAD, 32'h0, 4'd6, 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF, 1'b0);
    enq(OP_WR, 32'h2000, 4'd6, 128'hEEEEEEEE_EEEEEEEE_EEEEEEEE_EEEEEEEE, 1'b0);
    wait_idle("bad_reqs");
    chk("err_count", 128'(err_cnt - e0), 128'(2));
    chk("err_single_cycle", 128'(err_long), 128'(0));
    enq(OP_RD, 32'h0, 4'd8, '0, 1'b1);
    wait_idle("mem0_rd");

    // Reset during the access phase of a write leaves the old line intact.
    enq(OP_WR, 32'h80, 4'd0, 128'h00000000_11111111_22222222_33333333, 1'b1);
    wait_idle("line80_init");
    enq(OP_WR, 32'h80, 4'd0, 128'h99999999_88888888_77777777_66666666, 1'b0);
    n = 0;
    while (!busy && n < 50) begin
      step();
      n++;
    end
    chk("wait_busy", 128'(n < 50), 128'(1));
    step(5);
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    enq(OP_RD, 32'h80, 4'd7, '0, 1'b1);
    wait_idle("line80_rd");

    // Reset while beat 2 is on the bus ends the response at once.
    enq(OP_RD, 32'h80, 4'd7, '0, 1'b1);
    n = 0;
    while (sb.size() != 2 && n < 100) begin
      step();
      n++;
    end
    chk("wait_beat2", 128'(n < 100), 128'(1));
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_resp_valid_mid", 128'(resp_valid), 128'(0));
    chk("rst_busy_mid", 128'(busy), 128'(0));
    sb.delete();
    wait_idle("after_rst");

    // Three queued requests: one pop per service, never while busy or empty.
    p0 = pops;
    enq(OP_WR, 32'h100, 4'd1, 128'h01010101_02020202_03030303_04040404, 1'b1);
    enq(OP_PWB, 32'h110, 4'd1, 128'h50505050_60606060_70707070_80808080, 1'b1);
    enq(OP_RD, 32'h100, 4'd9, '0, 1'b1);
    wait_idle("three_reqs");
    chk("three_pops", 128'(pops - p0), 128'(3));
    enq(OP_RD, 32'h110, 4'd10, '0, 1'b1);
    wait_idle("pwb_rd");
    chk("pop_protocol", 128'(pop_viol), 128'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
